spi_master_core: RTL and testbench

SPI master shift engine, SPI mode 0 (CPOL=0, CPHA=0), MSB first. It sits directly downstream of the system clock divider. It generates SCLK internally from a half-period tick counter, drives CS_N and MOSI, and samples MISO. It provides a single-word start/done handshake to the host logic.

---
 rtl/spi_master_core.sv | 182 ++++++++++++++++++
 tb/tb_spi_master_core.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_core.sv
// ---------------------------------------------------------------------------
// spi_master_core
//   SPI mode 0 (CPOL=0, CPHA=0), MSB-first master shift engine. SCLK is built
//   from a half-period tick counter running on clk. One word is moved per
//   start/done handshake.
//
// Handshake: start is sampled only while the engine is idle; the cycle it
//   is seen high there is the accept cycle, and tx_data is captured on that
//   cycle only. busy is high from the cycle after accept until done. done is
//   a single-cycle pulse that coincides with the first idle cycle, and
//   rx_data is valid from that cycle until the next done. A start seen
//   during the done cycle is accepted (back-to-back). start while busy is
//   dropped.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   start           transfer request (idle only)
//   tx_data         word to send, captured on accept
//   busy, done      transfer in progress / one-cycle completion pulse
//   rx_data         last received word
//   sclk, mosi      SPI clock (idles low) and master data out
//   miso            slave data in, assumed synchronous to clk
//   cs_n            active-low chip select
//   dbg_state_o     current FSM state, for observation only
// ---------------------------------------------------------------------------
module spi_master_core #(
  parameter int DATA_W = 8,
  parameter int DIV    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n,
  output logic [1:0]        dbg_state_o
);

  localparam int HC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BC_W = $clog2(DATA_W);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(DIV - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    TAIL  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [HC_W-1:0]   hc_q, hc_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  // Only the bits not yet on mosi are kept; the current bit lives in mosi_q.
  logic [DATA_W-2:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick;

  assign tick = (hc_q == HC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hc_q      <= '0;
      bit_cnt_q <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hc_q      <= hc_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hc_d      = hc_q;
    bit_cnt_d = bit_cnt_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    // Half-period counter free-runs outside IDLE and wraps on tick.
    if (state_q != IDLE) begin
      hc_d = tick ? '0 : hc_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        hc_d   = '0;
        sclk_d = 1'b0;
        if (start) begin
          tx_sr_d   = tx_data[DATA_W-2:0];
          mosi_d    = tx_data[DATA_W-1];
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
          state_d = XFER;
        end
      end
      XFER: begin
        if (tick) begin
          if (sclk_q) begin
            // Falling edge: advance mosi unless this was the last bit.
            sclk_d = 1'b0;
            if (bit_cnt_q == BC_LAST) begin
              state_d = TAIL;
            end else begin
              mosi_d    = tx_sr_q[DATA_W-2];
              tx_sr_d   = tx_sr_q << 1;
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            // Rising edge: sample miso.
            sclk_d  = 1'b1;
            rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
          end
        end
      end
      TAIL: begin
        sclk_d = 1'b0;
        if (tick) begin
          cs_n_d    = 1'b1;
          mosi_d    = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign rx_data     = rx_data_q;
  assign sclk        = sclk_q;
  assign mosi        = mosi_q;
  assign cs_n        = cs_n_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_master_core.sv
// ---------------------------------------------------------------------------
// tb_spi_master_core
//   Two instances: the default configuration (DATA_W=8, DIV=4) and a corner
//   configuration (DATA_W=16, DIV=1). Each has a behavioural slave that
//   loads its word when cs_n falls and shifts on falling sclk. Expected
//   timing comes from the closed-form transfer schedule: with accept on
//   posedge number ka, done is visible right after posedge
//   ka + (2*DATA_W+1)*DIV, busy is high for (2*DATA_W+1)*DIV cycles, and
//   the mosi bits seen at sclk rises spell tx_data MSB first.
// ---------------------------------------------------------------------------
module tb_spi_master_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  // Default instance signals
  logic        a_start = 1'b0;
  logic [7:0]  a_tx = '0;
  logic        a_busy, a_done, a_sclk, a_mosi, a_cs_n;
  logic [7:0]  a_rx;
  logic        a_miso = 1'b0;
  logic [1:0]  a_state;
  logic [7:0]  a_slv_word = '0;
  logic [7:0]  a_slv = '0;

  // Corner instance signals
  logic        b_start = 1'b0;
  logic [15:0] b_tx = '0;
  logic        b_busy, b_done, b_sclk, b_mosi, b_cs_n;
  logic [15:0] b_rx;
  logic        b_miso = 1'b0;
  logic [1:0]  b_state;
  logic [15:0] b_slv_word = '0;
  logic [15:0] b_slv = '0;

  spi_master_core #(.DATA_W(8), .DIV(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .tx_data(a_tx),
    .busy(a_busy), .done(a_done), .rx_data(a_rx), .sclk(a_sclk),
    .mosi(a_mosi), .miso(a_miso), .cs_n(a_cs_n), .dbg_state_o(a_state)
  );

  spi_master_core #(.DATA_W(16), .DIV(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .tx_data(b_tx),
    .busy(b_busy), .done(b_done), .rx_data(b_rx), .sclk(b_sclk),
    .mosi(b_mosi), .miso(b_miso), .cs_n(b_cs_n), .dbg_state_o(b_state)
  );

  // Clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave models: word loaded at cs_n fall, next bit presented at sclk fall.
  always @(negedge a_cs_n) begin
    a_slv  <= a_slv_word;
    a_miso <= a_slv_word[7];
  end
  always @(negedge a_sclk) begin
    if (!a_cs_n) begin
      a_slv  <= a_slv << 1;
      a_miso <= a_slv[6];
    end
  end
  always @(negedge b_cs_n) begin
    b_slv  <= b_slv_word;
    b_miso <= b_slv_word[15];
  end
  always @(negedge b_sclk) begin
    if (!b_cs_n) begin
      b_slv  <= b_slv << 1;
      b_miso <= b_slv[14];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {cs_n, sclk, mosi, busy, done, rx_data}
  task automatic check_idle_a(input string tag);
    chk(tag, {19'd0, a_cs_n, a_sclk, a_mosi, a_busy, a_done, a_rx}, 32'h0000_1000);
  endtask

  // One transfer on instance sel (0: default, 1: corner), checked against
  // the closed-form schedule. disturb pulses start and changes tx_data at
  // 10 and 40 cycles after accept (default instance only).
  task automatic run_xfer(input bit sel, input logic [15:0] tx, input logic [15:0] slv,
                          input bit disturb);
    int dw, dv, len, ka, offs;
    int rises, busy_cnt, dones, csn_rises, done_at, first_rise, last_rise;
    logic [15:0] mask, mosi_word, rx_seen;
    logic s, m, b, d, c, prev_s, prev_c;
    dw = sel ? 16 : 8;
    dv = sel ? 1 : 4;
    mask = sel ? 16'hFFFF : 16'h00FF;
    len = (2 * dw + 1) * dv;
    rises = 0; busy_cnt = 0; dones = 0; csn_rises = 0;
    done_at = -1; first_rise = -1; last_rise = -1;
    mosi_word = '0; rx_seen = '0;
    @(negedge clk);
    if (sel) begin
      b_slv_word = slv; b_tx = tx; b_start = 1'b1;
    end else begin
      a_slv_word = slv[7:0]; a_tx = tx[7:0]; a_start = 1'b1;
    end
    ka = cyc + 1;
    prev_s = 1'b0;
    prev_c = 1'b1;
    for (int n = 0; n < len + 20; n++) begin
      @(negedge clk);
      offs = cyc - ka;
      if (sel) begin
        b_start = 1'b0;
      end else begin
        a_start = disturb && (offs == 10 || offs == 40);
        if (disturb && (offs == 10 || offs == 40)) a_tx = 8'($urandom);
      end
      s = sel ? b_sclk : a_sclk;
      m = sel ? b_mosi : a_mosi;
      b = sel ? b_busy : a_busy;
      d = sel ? b_done : a_done;
      c = sel ? b_cs_n : a_cs_n;
      if (s && !prev_s) begin
        mosi_word = {mosi_word[14:0], m};
        rises++;
        if (first_rise < 0) first_rise = cyc;
        last_rise = cyc;
      end
      if (b) busy_cnt++;
      if (c && !prev_c) csn_rises++;
      if (d) begin
        dones++;
        done_at = cyc;
        rx_seen = sel ? b_rx : {8'h00, a_rx};
      end
      prev_s = s;
      prev_c = c;
    end
    chk("done_count", dones, 1);
    chk("done_cycle", done_at, ka + len);
    chk("rx_data", rx_seen, slv & mask);
    chk("mosi_bits", mosi_word & mask, tx & mask);
    chk("sclk_rises", rises, dw);
    chk("sclk_period", last_rise - first_rise, 2 * dv * (dw - 1));
    chk("first_rise", first_rise, ka + dv);
    chk("busy_cycles", busy_cnt, len);
    chk("cs_n_rises", csn_rises, 1);
  endtask

  initial begin
    int ka, d1, d2, cs_fall2, cs_high, rises;
    logic [15:0] mosi16;
    logic [7:0] w1, w2, rx1, rx2;
    logic prev_s, prev_c, seen_done;

    // Reset idle
    repeat (3) @(negedge clk);
    check_idle_a("in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle_a("reset_idle");
    end
    chk("reset_idle_b", {b_cs_n, b_sclk, b_mosi, b_busy, b_done, b_rx}, 21'h10_0000);

    // Single transfer, defaults
    run_xfer(1'b0, 16'h00A5, 16'h003C, 1'b0);

    // Random transfers on both configurations
    for (int i = 0; i < 6; i++) run_xfer(1'b0, 16'($urandom), 16'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) run_xfer(1'b1, 16'($urandom), 16'($urandom), 1'b0);

    // Back-to-back with start held high
    w1 = 8'($urandom);
    w2 = 8'($urandom);
    d1 = -1; d2 = -1; cs_fall2 = -1; cs_high = 0; rises = 0;
    mosi16 = '0; rx1 = '0; rx2 = '0;
    prev_s = 1'b0; prev_c = 1'b1;
    @(negedge clk);
    a_tx = 8'hFF; a_slv_word = w1; a_start = 1'b1;
    ka = cyc + 1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (n == 0) begin
        a_tx = 8'h00;
        a_slv_word = w2;
      end
      if (a_sclk && !prev_s) begin
        mosi16 = {mosi16[14:0], a_mosi};
        rises++;
      end
      if (!a_cs_n && prev_c && n > 0 && cs_fall2 < 0) cs_fall2 = cyc;
      if (a_done) begin
        if (d1 < 0) begin
          d1 = cyc; rx1 = a_rx;
        end else if (d2 < 0) begin
          d2 = cyc; rx2 = a_rx; a_start = 1'b0;
        end
      end
      if (a_cs_n && d1 >= 0 && d2 < 0) cs_high++;
      prev_s = a_sclk;
      prev_c = a_cs_n;
      if (d2 >= 0 && cyc > d2 + 5) break;
    end
    a_start = 1'b0;
    chk("b2b_done1", d1, ka + 68);
    chk("b2b_done2", d2, d1 + 69);
    chk("b2b_cs_fall2", cs_fall2, d1 + 1);
    chk("b2b_cs_high", cs_high, 1);
    chk("b2b_mosi", mosi16, 16'hFF00);
    chk("b2b_rises", rises, 16);
    chk("b2b_rx1", rx1, w1);
    chk("b2b_rx2", rx2, w2);
    repeat (80) @(negedge clk);

    // Ignored start and tx_data change during a transfer
    run_xfer(1'b0, 16'h0081, 16'($urandom), 1'b1);

    // Reset mid-transfer
    @(negedge clk);
    a_tx = 8'($urandom); a_slv_word = 8'($urandom); a_start = 1'b1;
    ka = cyc + 1;
    @(negedge clk);
    a_start = 1'b0;
    for (int n = 0; n < 60 && (cyc - ka) < 30; n++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_cs_sclk_busy", {a_cs_n, a_sclk, a_busy}, 3'b100);
    chk("midrst_rx", a_rx, 8'h00);
    seen_done = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      seen_done = seen_done | a_done;
    end
    rst_n = 1'b1;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      seen_done = seen_done | a_done;
    end
    chk("midrst_no_done", seen_done, 1'b0);
    check_idle_a("midrst_idle");
    run_xfer(1'b0, 16'($urandom), 16'($urandom), 1'b0);

    // Parameter corner: DIV=1, DATA_W=16, miso held at 1
    run_xfer(1'b1, 16'h8001, 16'hFFFF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
